// File: rtl/spi_feeder.sv
// spi_feeder
//   CPU-fed command FIFO that drains entries into an SPI master's Avalon
//   slave port. Each entry is issued only after a status poll shows the
//   shifter idle, and consecutive writes are separated by at least three
//   cycles (ISSUE, SETTLE, POLL).
//
//   Optional feature: define SPI_FEEDER_REPEAT_EN to enable repeat entries
//   (bit 31 set, bits [30:16] = repeat count). When undefined, every entry
//   is a plain entry and produces exactly one SPI write.
//
//   Handshake semantics (all strobes are single-cycle, no wait states):
//     avs_write  - an entry is accepted on the rising edge when the FIFO is
//                  not full; when full it is dropped and overflow is set.
//     avs_read   - avs_readdata is combinational; the read edge clears
//                  overflow unless a new overflow happens in that same cycle.
//     avm_read   - held high in POLL; avm_readdata[0] is sampled the same
//                  cycle (1 = shifter busy).
//     avm_write  - one-cycle pulse in ISSUE; the SPI master always accepts.
//   dbg_state exposes the drain FSM state for checkers.
module spi_feeder #(
  parameter int DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  input  logic        avs_read,
  output logic [31:0] avs_readdata,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  output logic [1:0]  dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_POLL   = 2'd1,
    ST_ISSUE  = 2'd2,
    ST_SETTLE = 2'd3
  } state_t;

  // FIFO storage and bookkeeping
  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          ovf_q, ovf_d;

  // Drain FSM
  state_t        state_q, state_d;
  logic [14:0]   rem_q, rem_d;

  // Derived signals
  logic          full, empty, push, pop, active;
  logic [31:0]   head, next_head;
  logic [14:0]   head_cnt, next_cnt;
  logic          head_dc;
  logic [8:0]    lvl_ext;
  logic          unused_ok;

  assign full  = (level_q == LW'(DEPTH));
  assign empty = (level_q == '0);
  assign push  = avs_write && !full;
  assign dbg_state = state_q;

  // Head entry decode; next_head is only looked at when a second entry exists
  always_comb begin
    head      = mem_q[rd_ptr_q];
    next_head = mem_q[rd_ptr_q + AW'(1)];
`ifdef SPI_FEEDER_REPEAT_EN
    head_cnt  = head[31] ? head[30:16] : 15'd1;
    next_cnt  = next_head[31] ? next_head[30:16] : 15'd1;
    head_dc   = head[31] | head[16];
`else
    head_cnt  = 15'd1;
    next_cnt  = 15'd1;
    head_dc   = head[16];
`endif
  end

  // Bits that have no function in the selected configuration
`ifdef SPI_FEEDER_REPEAT_EN
  assign unused_ok = ^{next_head[15:0], avm_readdata[31:1], lvl_ext[8]};
`else
  assign unused_ok = ^{head[31:17], next_head, avm_readdata[31:1], lvl_ext[8]};
`endif

  // Entry storage; no reset needed because the level gates every read
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      mem_q[wr_ptr_q] <= avs_writedata;
    end
  end

  // FIFO pointer, level and overflow next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (push && !pop) begin
      level_d = level_q + LW'(1);
    end else if (!push && pop) begin
      level_d = level_q - LW'(1);
    end
    // A refused push wins over a clearing read in the same cycle
    if (avs_write && full) begin
      ovf_d = 1'b1;
    end else if (avs_read) begin
      ovf_d = 1'b0;
    end
  end

  // Drain FSM next-state, remaining count and pop request
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    pop     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          if (head_cnt == '0) begin
            // Zero-count repeat entry is discarded without touching the SPI
            pop = 1'b1;
          end else begin
            state_d = ST_POLL;
            rem_d   = head_cnt;
          end
        end
      end
      ST_POLL: begin
        if (!avm_readdata[0]) begin
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (rem_q > 15'd1) begin
          rem_d   = rem_q - 15'd1;
          state_d = ST_POLL;
        end else begin
          pop = 1'b1;
          // Chain straight into the next entry unless it is a zero-count
          // repeat, which IDLE discards on its own
          if ((level_q > LW'(1)) && (next_cnt != '0)) begin
            state_d = ST_POLL;
            rem_d   = next_cnt;
          end else begin
            state_d = ST_IDLE;
            rem_d   = '0;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        rem_d   = '0;
      end
    endcase
  end

  // Drain FSM outputs; strobes are forced low while reset is asserted
  always_comb begin
    avm_read      = 1'b0;
    avm_write     = 1'b0;
    avm_writedata = '0;
    if (!reset) begin
      if (state_q == ST_POLL) begin
        avm_read = 1'b1;
      end
      if (state_q == ST_ISSUE) begin
        avm_write     = 1'b1;
        avm_writedata = {15'd0, head_dc, head[15:0]};
      end
    end
  end

  // CPU status word, combinational from current state
  always_comb begin
    lvl_ext = 9'(level_q);
    active  = (state_q != ST_IDLE) || !empty;
    if (reset) begin
      avs_readdata = 32'h0000_0002;
    end else begin
      avs_readdata = {16'd0, lvl_ext[7:0], 4'd0, ovf_q, active, empty, full};
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      state_q  <= ST_IDLE;
      rem_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      state_q  <= state_d;
      rem_q    <= rem_d;
    end
  end

endmodule
